melody_sequencer: RTL and testbench
===================================

MELODY_SEQUENCER -- requirements
Module: melody_sequencer

Interface
REQ-001 SHALL have parameter TICK_CYCLES, default 6_250_000, clk cycles per duration tick (1/16 s at 100 MHz).
REQ-002 SHALL have parameter GAP_CYCLES, default 500_000, silent clk cycles between consecutive notes; legal range 1..2^24-1.
REQ-003 SHALL have port clk  input  1  system clock, 100 MHz, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port note_valid  input  1  upstream offers a note.
REQ-006 SHALL have port note_hz  input  12  note frequency in Hz; 0 = rest.
REQ-007 SHALL have port note_len  input  4  note duration code; duration = (note_len+1) ticks.
REQ-008 SHALL have port note_ready  output  1  sequencer can accept a note this cycle.
REQ-009 SHALL have port play  input  1  level; 1 = run, 0 = pause.
REQ-010 SHALL have port clear  input  1  single-cycle flush request.
REQ-011 SHALL have port hz_next  output  12  frequency to the downstream buzzer player; 0 = silence.
REQ-012 SHALL have port note_done  output  1  one-cycle pulse at the end of each note's sounding period.
REQ-013 SHALL have port busy  output  1  high whenever the state is not IDLE.
REQ-014 SHALL have port level  output  5  number of queued notes, 0..16.

Function
REQ-015 SHALL buffer notes in a 16-entry FIFO of {note_hz, note_len}; a push occurs when note_valid && note_ready.
REQ-016 SHALL drive note_ready = (level < 16) && !clear, combinationally from registered level.
REQ-017 SHALL, on a push and pop in the same cycle, leave level unchanged and preserve FIFO order; read/write pointers wrap modulo 16.
REQ-018 SHALL implement states IDLE, PLAY, GAP.
REQ-019 SHALL in IDLE, when play=1 and level>0, pop the head note into cur_hz/cur_len and enter PLAY next cycle.
REQ-020 SHALL in PLAY, with play=1, advance a cycle counter 0..TICK_CYCLES-1 and a tick counter 0..cur_len; both freeze while play=0.
REQ-021 SHALL, on the cycle where the cycle counter = TICK_CYCLES-1 and the tick counter = cur_len (play=1), assert note_done for that cycle and enter GAP.
REQ-022 SHALL in GAP count GAP_CYCLES cycles (frozen while play=0); on the last count, if level>0, pop and enter PLAY, else enter IDLE.
REQ-023 SHALL drive hz_next = cur_hz in PLAY with play=1, and 0 in every other state or while play=0, as a registered output.
REQ-024 SHALL thereby sound each note with hz_next = note_hz for exactly (note_len+1)*TICK_CYCLES unpaused cycles, followed by exactly GAP_CYCLES cycles of 0.
REQ-025 SHALL treat a note with note_hz=0 as a timed rest; it still produces note_done.
REQ-026 SHALL, on clear=1, at the next edge empty the FIFO (level=0), return to IDLE, and zero hz_next and all counters; clear overrides a simultaneous push, pop and note_done.
REQ-027 SHALL keep hz_next stable for the whole note so the downstream player, which samples its input only at waveform half-period boundaries, sees no glitches.

Reset
REQ-028 SHALL, on rst=1, immediately force state=IDLE, level=0, pointers=0, counters=0, hz_next=0, note_done=0; busy=0 and note_ready=1 follow.
REQ-029 SHALL abort any note in progress on reset mid-operation, with no note_done pulse; FIFO contents are discarded.

Verification (TICK_CYCLES=4, GAP_CYCLES=2)
REQ-030 SHALL cover: push {440,len 1}, play=1 -> hz_next=440 for 8 cycles, note_done pulses on the 8th, hz_next=0 for 2 cycles, then IDLE with busy=0.
REQ-031 SHALL cover: push 17 notes back-to-back with play=0 -> 16 accepted, note_ready=0 at level=16, 17th held until the first pop.
REQ-032 SHALL cover: pushes of 262, 330 and 392 with len 0 -> hz_next sequence 262(4),0(2),330(4),0(2),392(4),0(2) with 3 note_done pulses.
REQ-033 SHALL cover: play dropped for 5 cycles mid-note -> hz_next=0 during the pause, and the note still totals 8 sounding cycles.
REQ-034 SHALL cover: clear asserted during PLAY with level=3 and note_valid=1 -> next cycle level=0, hz_next=0, IDLE, and no push.
REQ-035 SHALL cover: rst asserted mid-GAP -> outputs reach reset values without waiting for a clock edge, and no note_done pulse occurs.

Source files
------------

// File: rtl/melody_sequencer.sv
// -----------------------------------------------------------------------------
// melody_sequencer
//
// Queues notes in a 16-entry FIFO and plays them one after another to a
// downstream buzzer player. Each note sounds for (note_len+1) duration ticks
// and is followed by a fixed silent gap. A note with note_hz = 0 is a timed
// rest. The play level pauses everything in place. The clear input flushes
// the queue and stops playback.
//
// Ports
//   clk         in   system clock, rising edge
//   rst         in   asynchronous active-high reset
//   note_valid  in   upstream offers a note
//   note_hz     in   [11:0] note frequency in Hz, 0 = rest
//   note_len    in   [3:0]  duration code, duration = (note_len+1) ticks
//   note_ready  out  a note offered this cycle is accepted
//   play        in   level: 1 = run, 0 = pause
//   clear       in   single-cycle flush request
//   hz_next     out  [11:0] registered frequency to the player, 0 = silence
//   note_done   out  registered one-cycle pulse at the end of each note
//   busy        out  sequencer is not idle
//   level       out  [4:0] number of queued notes, 0..16
//
// hz_next and note_done are registered from the cycle that does the counting,
// so both appear one cycle after that cycle and stay aligned with each other:
// note_done coincides with the last sounding cycle seen on hz_next.
// -----------------------------------------------------------------------------
module melody_sequencer #(
  parameter int TICK_CYCLES = 6_250_000,
  parameter int GAP_CYCLES  = 500_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        note_valid,
  input  logic [11:0] note_hz,
  input  logic [3:0]  note_len,
  output logic        note_ready,
  input  logic        play,
  input  logic        clear,
  output logic [11:0] hz_next,
  output logic        note_done,
  output logic        busy,
  output logic [4:0]  level
);

  localparam int CYC_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int GAP_W = 24;

  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(TICK_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  // FIFO storage: {hz, len}. Data only, so no reset.
  logic [15:0]      r_mem [16];
  logic [3:0]       r_wptr;
  logic [3:0]       r_rptr;
  logic [4:0]       r_level;

  // Current note, loaded on every pop.
  logic [11:0]      r_cur_hz;
  logic [3:0]       r_cur_len;

  // Playback control
  state_t           r_state;
  logic [CYC_W-1:0] r_cyc;
  logic [3:0]       r_tick;
  logic [GAP_W-1:0] r_gap;
  logic [11:0]      r_hz_next;
  logic             r_note_done;

  // Next-state values
  state_t           w_state_n;
  logic [CYC_W-1:0] w_cyc_n;
  logic [3:0]       w_tick_n;
  logic [GAP_W-1:0] w_gap_n;
  logic             w_note_done_n;
  logic [11:0]      w_hz_n;
  logic             w_pop;
  logic             w_push;
  logic             w_has_note;
  logic [4:0]       w_level_n;

  assign w_has_note = (r_level != 5'd0);
  assign note_ready = (r_level < 5'd16) && !clear;
  assign w_push     = note_valid && note_ready;

  // ---------------------------------------------------------------------------
  // Next-state / counter logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_n     = r_state;
    w_cyc_n       = r_cyc;
    w_tick_n      = r_tick;
    w_gap_n       = r_gap;
    w_note_done_n = 1'b0;
    w_pop         = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (play && w_has_note) begin
          w_pop     = 1'b1;
          w_state_n = S_PLAY;
          w_cyc_n   = '0;
          w_tick_n  = '0;
        end
      end

      S_PLAY: begin
        if (play) begin
          if (r_cyc == CYC_LAST) begin
            w_cyc_n = '0;
            if (r_tick == r_cur_len) begin
              w_note_done_n = 1'b1;
              w_state_n     = S_GAP;
              w_tick_n      = '0;
              w_gap_n       = '0;
            end else begin
              w_tick_n = r_tick + 4'd1;
            end
          end else begin
            w_cyc_n = r_cyc + CYC_W'(1);
          end
        end
      end

      S_GAP: begin
        if (play) begin
          if (r_gap == GAP_LAST) begin
            w_gap_n = '0;
            if (w_has_note) begin
              w_pop     = 1'b1;
              w_state_n = S_PLAY;
              w_cyc_n   = '0;
              w_tick_n  = '0;
            end else begin
              w_state_n = S_IDLE;
            end
          end else begin
            w_gap_n = r_gap + GAP_W'(1);
          end
        end
      end

      default: begin
        w_state_n = S_IDLE;
      end
    endcase

    // Flush wins over everything scheduled for this edge.
    if (clear) begin
      w_state_n     = S_IDLE;
      w_cyc_n       = '0;
      w_tick_n      = '0;
      w_gap_n       = '0;
      w_note_done_n = 1'b0;
      w_pop         = 1'b0;
    end
  end

  // Sound only on cycles that actually advance the note.
  always_comb begin
    w_hz_n = 12'd0;
    if ((r_state == S_PLAY) && play && !clear) begin
      w_hz_n = r_cur_hz;
    end
  end

  always_comb begin
    w_level_n = r_level;
    if (clear) begin
      w_level_n = 5'd0;
    end else if (w_push && !w_pop) begin
      w_level_n = r_level + 5'd1;
    end else if (w_pop && !w_push) begin
      w_level_n = r_level - 5'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Control registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cyc       <= '0;
      r_tick      <= '0;
      r_gap       <= '0;
      r_hz_next   <= '0;
      r_note_done <= 1'b0;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_level     <= '0;
    end else begin
      r_state     <= w_state_n;
      r_cyc       <= w_cyc_n;
      r_tick      <= w_tick_n;
      r_gap       <= w_gap_n;
      r_hz_next   <= w_hz_n;
      r_note_done <= w_note_done_n;
      r_level     <= w_level_n;
      if (clear) begin
        r_wptr <= '0;
        r_rptr <= '0;
      end else begin
        if (w_push) r_wptr <= r_wptr + 4'd1;
        if (w_pop)  r_rptr <= r_rptr + 4'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Data registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= {note_hz, note_len};
    end
  end

  always_ff @(posedge clk) begin
    if (w_pop) begin
      r_cur_hz  <= r_mem[r_rptr][15:4];
      r_cur_len <= r_mem[r_rptr][3:0];
    end
  end

  assign hz_next   = r_hz_next;
  assign note_done = r_note_done;
  assign busy      = (r_state != S_IDLE);
  assign level     = r_level;

endmodule

// File: tb/tb_melody_sequencer.sv
module tb_melody_sequencer;

  localparam int TICK = 4;
  localparam int GAP  = 2;

  logic        clk;
  logic        rst;
  logic        note_valid;
  logic [11:0] note_hz;
  logic [3:0]  note_len;
  logic        note_ready;
  logic        play;
  logic        clear;
  logic [11:0] hz_next;
  logic        note_done;
  logic        busy;
  logic [4:0]  level;

  melody_sequencer #(
    .TICK_CYCLES(TICK),
    .GAP_CYCLES (GAP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .note_valid(note_valid),
    .note_hz   (note_hz),
    .note_len  (note_len),
    .note_ready(note_ready),
    .play      (play),
    .clear     (clear),
    .hz_next   (hz_next),
    .note_done (note_done),
    .busy      (busy),
    .level     (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [11:0] hz;
    logic        done;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      $error("%s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Expected output trace of one queued note: sounding cycles then gap cycles.
  task automatic sb_note(input logic [11:0] hz, input logic [3:0] len);
    int n;
    n = (int'(len) + 1) * TICK;
    for (int i = 0; i < n; i++) sb.push_back('{hz: hz, done: (i == n - 1)});
    for (int i = 0; i < GAP; i++) sb.push_back('{hz: 12'd0, done: 1'b0});
  endtask

  task automatic push_note(input logic [11:0] hz, input logic [3:0] len);
    note_valid = 1'b1;
    note_hz    = hz;
    note_len   = len;
    cyc();
    note_valid = 1'b0;
    sb_note(hz, len);
  endtask

  task automatic check_one(input string tag);
    exp_t e;
    cyc();
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk({tag, "_hz"}, 32'(hz_next), 32'(e.hz));
      chk({tag, "_done"}, 32'(note_done), 32'(e.done));
    end
  endtask

  task automatic check_stream(input string tag);
    while (sb.size() > 0) check_one(tag);
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    note_valid = 1'b0;
    note_hz    = '0;
    note_len   = '0;
    play       = 1'b0;
    clear      = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
    cyc();

    // Reset state
    chk("rst_hz",    32'(hz_next),    32'd0);
    chk("rst_done",  32'(note_done),  32'd0);
    chk("rst_busy",  32'(busy),       32'd0);
    chk("rst_level", 32'(level),      32'd0);
    chk("rst_ready", 32'(note_ready), 32'd1);

    // Single note 440 len 1: 8 sounding cycles, then 2 silent
    push_note(12'd440, 4'd1);
    chk("t1_level", 32'(level), 32'd1);
    play = 1'b1;
    cyc();
    chk("t1_lat_hz", 32'(hz_next), 32'd0);
    chk("t1_busy",   32'(busy),    32'd1);
    check_stream("t1");
    chk("t1_idle", 32'(busy), 32'd0);
    play = 1'b0;

    // Three short notes back to back
    push_note(12'd262, 4'd0);
    push_note(12'd330, 4'd0);
    push_note(12'd392, 4'd0);
    chk("t2_level", 32'(level), 32'd3);
    play = 1'b1;
    cyc();
    chk("t2_lat_hz", 32'(hz_next), 32'd0);
    check_stream("t2");
    chk("t2_idle", 32'(busy), 32'd0);
    play = 1'b0;

    // Fill: 17 offered back to back, only 16 fit
    note_valid = 1'b1;
    note_len   = 4'd0;
    for (int i = 0; i < 17; i++) begin
      note_hz = 12'(100 + i);
      sb_note(12'(100 + i), 4'd0);
      cyc();
    end
    chk("t3_full_level", 32'(level),      32'd16);
    chk("t3_full_ready", 32'(note_ready), 32'd0);
    play = 1'b1;
    cyc();
    chk("t3_pop_level", 32'(level),   32'd15);
    chk("t3_lat_hz",    32'(hz_next), 32'd0);
    check_one("t3_first");
    chk("t3_held_level", 32'(level), 32'd16);
    note_valid = 1'b0;
    check_stream("t3");
    chk("t3_idle", 32'(busy), 32'd0);
    play = 1'b0;

    // Pause mid-note
    push_note(12'd440, 4'd1);
    play = 1'b1;
    cyc();
    chk("t4_lat_hz", 32'(hz_next), 32'd0);
    for (int i = 0; i < 3; i++) check_one("t4_pre");
    play = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("t4_pause_hz",   32'(hz_next),   32'd0);
      chk("t4_pause_done", 32'(note_done), 32'd0);
    end
    chk("t4_pause_busy", 32'(busy), 32'd1);
    play = 1'b1;
    check_stream("t4");
    chk("t4_idle", 32'(busy), 32'd0);
    play = 1'b0;

    // Clear during PLAY with a push offered
    push_note(12'd500, 4'd3);
    push_note(12'd510, 4'd3);
    push_note(12'd520, 4'd3);
    push_note(12'd530, 4'd3);
    play = 1'b1;
    cyc();
    chk("t5_level", 32'(level), 32'd3);
    cyc();
    chk("t5_hz", 32'(hz_next), 32'd500);
    clear      = 1'b1;
    note_valid = 1'b1;
    note_hz    = 12'd777;
    #1;
    chk("t5_ready_clr", 32'(note_ready), 32'd0);
    cyc();
    clear      = 1'b0;
    note_valid = 1'b0;
    chk("t5_clr_level", 32'(level),     32'd0);
    chk("t5_clr_hz",    32'(hz_next),   32'd0);
    chk("t5_clr_busy",  32'(busy),      32'd0);
    chk("t5_clr_done",  32'(note_done), 32'd0);
    cyc();
    chk("t5_after_busy", 32'(busy),    32'd0);
    chk("t5_after_hz",   32'(hz_next), 32'd0);
    play = 1'b0;
    sb.delete();

    // Async reset mid-GAP
    push_note(12'd600, 4'd0);
    push_note(12'd700, 4'd0);
    play = 1'b1;
    cyc();
    chk("t6_lat_hz", 32'(hz_next), 32'd0);
    for (int i = 0; i < 5; i++) check_one("t6");
    chk("t6_gap_busy",  32'(busy),  32'd1);
    chk("t6_gap_level", 32'(level), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_busy",  32'(busy),       32'd0);
    chk("t6_rst_level", 32'(level),      32'd0);
    chk("t6_rst_ready", 32'(note_ready), 32'd1);
    chk("t6_rst_hz",    32'(hz_next),    32'd0);
    chk("t6_rst_done",  32'(note_done),  32'd0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("t6_hold_done", 32'(note_done), 32'd0);
      chk("t6_hold_hz",   32'(hz_next),   32'd0);
    end
    rst  = 1'b0;
    play = 1'b0;
    sb.delete();
    cyc();
    chk("t6_post_busy", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
